// File: rtl/pid_pwm_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pid_pwm_out                                                     |
// | Brief    : PID output stage. Signed power word to sign/magnitude PWM with  |
// |            period-aligned updates. Define PID_PWM_DEADTIME_EN for one      |
// |            period of suppressed drive on each direction reversal.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pid_pwm_out #(
  parameter int aw = 1,
  parameter int ow = 12
) (
  input  logic              clk_pid,
  input  logic              reset,
  input  logic              ce,
  input  logic [aw-1:0]     a,
  input  logic [ow-1:0]     m_k,
  output logic [(1<<aw)-1:0] pwm_out,
  output logic [(1<<aw)-1:0] dir_out,
  output logic              sync
);

  localparam int c_an = 1 << aw;
  localparam int c_mw = ow - 1;
  localparam logic [c_mw-1:0] c_pmax = {{(c_mw-1){1'b1}}, 1'b0};

  logic            r_ce_d;
  logic [c_mw-1:0] r_cnt;
  logic            r_sync;
  logic            w_cap;
  logic            w_bound;
  logic [ow-1:0]   w_abs;
  logic [c_mw-1:0] w_mag;

  assign w_cap   = ce & ~r_ce_d;
  assign w_bound = (r_cnt == c_pmax);

  // Negating the most negative word leaves bit ow-1 set; that case saturates.
  assign w_abs = m_k[ow-1] ? ({ow{1'b0}} - m_k) : m_k;
  assign w_mag = w_abs[ow-1] ? {c_mw{1'b1}} : w_abs[c_mw-1:0];

  always_ff @(posedge clk_pid) begin
    if (reset) begin
      r_ce_d <= 1'b0;
      r_cnt  <= '0;
      r_sync <= 1'b0;
    end else begin
      r_ce_d <= ce;
      r_cnt  <= w_bound ? '0 : r_cnt + 1'b1;
      r_sync <= w_bound;
    end
  end

  assign sync = r_sync;

  for (genvar i = 0; i < c_an; i++) begin : g_chan
    localparam logic [aw-1:0] c_idx = aw'(i);

    logic            r_pend_sign;
    logic [c_mw-1:0] r_pend_mag;
    logic            r_act_dir;
    logic [c_mw-1:0] r_act_mag;
    logic            r_pwm;
    logic            r_dir;
`ifdef PID_PWM_DEADTIME_EN
    logic            r_dead;
    logic            w_hold;
    assign w_hold = ~r_dead & (r_pend_sign != r_act_dir) & (r_act_mag != '0);
`endif

    always_ff @(posedge clk_pid) begin
      if (reset) begin
        r_pend_sign <= 1'b0;
        r_pend_mag  <= '0;
        r_act_dir   <= 1'b0;
        r_act_mag   <= '0;
        r_pwm       <= 1'b0;
        r_dir       <= 1'b0;
`ifdef PID_PWM_DEADTIME_EN
        r_dead      <= 1'b0;
`endif
      end else begin
        if (w_cap && (a == c_idx)) begin
          r_pend_sign <= m_k[ow-1];
          r_pend_mag  <= w_mag;
        end
        // Non-blocking reads make a same-edge load take the pre-capture value.
        if (w_bound) begin
`ifdef PID_PWM_DEADTIME_EN
          if (w_hold) begin
            r_act_mag <= '0;
            r_dead    <= 1'b1;
          end else begin
            r_act_dir <= r_pend_sign;
            r_act_mag <= r_pend_mag;
            r_dead    <= 1'b0;
          end
`else
          r_act_dir <= r_pend_sign;
          r_act_mag <= r_pend_mag;
`endif
        end
        r_pwm <= (r_cnt < r_act_mag);
        r_dir <= r_act_dir;
      end
    end

    assign pwm_out[i] = r_pwm;
    assign dir_out[i] = r_dir;
  end

endmodule
`default_nettype wire

// File: tb/tb_pid_pwm_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pid_pwm_out                                                  |
// | Brief    : Directed self-checking bench for pid_pwm_out (aw=1, ow=12).     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pid_pwm_out;

  localparam int c_period = 2047;

  logic       clk_pid = 1'b0;
  logic       reset;
  logic       ce;
  logic [0:0] a;
  logic [11:0] m_k;
  logic [1:0] pwm_out;
  logic [1:0] dir_out;
  logic       sync;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_pid = ~clk_pid;

  pid_pwm_out dut (
    .clk_pid (clk_pid),
    .reset   (reset),
    .ce      (ce),
    .a       (a),
    .m_k     (m_k),
    .pwm_out (pwm_out),
    .dir_out (dir_out),
    .sync    (sync)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_sync(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk_pid);
      n++;
    end while (sync !== 1'b1 && n < 3000);
    if (n >= 3000) check({tag, "_timeout"}, 32'(sync), 32'd1);
  endtask

  // Starts on a sync cycle; samples the following full output period.
  task automatic run_period(input string tag, output int h0, output int h1,
                            output int d0, output int d1);
    int   s_mid;
    logic s_last;
    h0 = 0; h1 = 0; d0 = 0; d1 = 0; s_mid = 0; s_last = 1'b0;
    for (int i = 0; i < c_period; i++) begin
      @(negedge clk_pid);
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      d0 += int'(dir_out[0]);
      d1 += int'(dir_out[1]);
      if (i < c_period - 1) s_mid += int'(sync);
      else s_last = sync;
    end
    check({tag, "_sync_mid"}, 32'(s_mid), 32'd0);
    check({tag, "_sync_last"}, 32'(s_last), 32'd1);
  endtask

  task automatic cap(input logic ch, input int v, input int hold);
    ce  = 1'b1;
    a   = ch;
    m_k = v[11:0];
    repeat (hold) @(negedge clk_pid);
    ce  = 1'b0;
    a   = ~ch;
    m_k = 12'h5A5;
    @(negedge clk_pid);
  endtask

  task automatic count_to_sync(input string tag);
    int n;
    int bad;
    n = 0; bad = 0;
    do begin
      @(negedge clk_pid);
      n++;
      if (pwm_out !== 2'b00 || dir_out !== 2'b00) bad++;
    end while (sync !== 1'b1 && n < 3000);
    check({tag, "_first_sync"}, 32'(n), 32'd2047);
    check({tag, "_idle_outputs"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int h0, h1, d0, d1;
    reset = 1'b1; ce = 1'b0; a = 1'b0; m_k = '0;
    repeat (3) @(negedge clk_pid);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_dir", 32'(dir_out), 32'd0);
    check("rst_sync", 32'(sync), 32'd0);

    reset = 1'b0;
    count_to_sync("boot");
    @(negedge clk_pid);
    check("sync_one_cycle", 32'(sync), 32'd0);

    // +512 on channel 0
    cap(1'b0, 512, 4);
    wait_sync("s512");
    run_period("p512", h0, h1, d0, d1);
    check("p512_h0", 32'(h0), 32'd512);
    check("p512_d0", 32'(d0), 32'd0);
    check("p512_h1", 32'(h1), 32'd0);
    check("p512_d1", 32'(d1), 32'd0);

    // most negative word saturates to full duty
    cap(1'b1, -2048, 3);
    wait_sync("sneg");
    run_period("pneg", h0, h1, d0, d1);
    check("pneg_h1", 32'(h1), 32'd2047);
    check("pneg_d1", 32'(d1), 32'd2047);
    check("pneg_h0", 32'(h0), 32'd512);

    cap(1'b1, 0, 2);
    wait_sync("szero");
    run_period("pzero", h0, h1, d0, d1);
    check("pzero_h1", 32'(h1), 32'd0);
    check("pzero_d1", 32'(d1), 32'd0);

    // ce held high while m_k steps: only the rising-edge value counts
    ce = 1'b1; a = 1'b0;
    m_k = 12'd100; @(negedge clk_pid); @(negedge clk_pid);
    m_k = 12'd200; @(negedge clk_pid); @(negedge clk_pid);
    m_k = 12'd300; @(negedge clk_pid); @(negedge clk_pid);
    ce = 1'b0;
    wait_sync("shold");
    run_period("phold", h0, h1, d0, d1);
    check("phold_h0", 32'(h0), 32'd100);
    check("phold_d0", 32'(d0), 32'd0);

    // reversal on ch0 (active 100) and on ch1 from zero magnitude
    cap(1'b0, -100, 2);
    cap(1'b1, -5, 2);
    wait_sync("srev");
    run_period("prev1", h0, h1, d0, d1);
    check("prev1_h1", 32'(h1), 32'd5);
    check("prev1_d1", 32'(d1), 32'd2047);
`ifdef PID_PWM_DEADTIME_EN
    check("prev1_h0", 32'(h0), 32'd0);
    check("prev1_d0", 32'(d0), 32'd0);
    run_period("prev2", h0, h1, d0, d1);
    check("prev2_h0", 32'(h0), 32'd100);
    check("prev2_d0", 32'(d0), 32'd2047);
`else
    check("prev1_h0", 32'(h0), 32'd100);
    check("prev1_d0", 32'(d0), 32'd2047);
`endif

    // capture on the cnt==PMAX cycle: old duty runs one more period
    repeat (c_period - 1) @(negedge clk_pid);
    ce = 1'b1; a = 1'b0; m_k = 12'hED4;  // -300
    @(negedge clk_pid);
    check("coll_sync", 32'(sync), 32'd1);
    ce = 1'b0;
    run_period("pcol1", h0, h1, d0, d1);
    check("pcol1_h0", 32'(h0), 32'd100);
    check("pcol1_d0", 32'(d0), 32'd2047);
    run_period("pcol2", h0, h1, d0, d1);
    check("pcol2_h0", 32'(h0), 32'd300);
    check("pcol2_d0", 32'(d0), 32'd2047);

    // reset mid-period
    repeat (100) @(negedge clk_pid);
    check("pre_rst_pwm0", 32'(pwm_out[0]), 32'd1);
    check("pre_rst_dir0", 32'(dir_out[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk_pid);
    check("mid_rst_pwm", 32'(pwm_out), 32'd0);
    check("mid_rst_dir", 32'(dir_out), 32'd0);
    check("mid_rst_sync", 32'(sync), 32'd0);
    @(negedge clk_pid);
    reset = 1'b0;
    count_to_sync("reboot");
    run_period("ppost", h0, h1, d0, d1);
    check("ppost_h0", 32'(h0), 32'd0);
    check("ppost_h1", 32'(h1), 32'd0);
    check("ppost_d", 32'(d0 + d1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pid_pwm_out.md
# pid_pwm_out

Output stage placed directly downstream of the PID controller core. It captures each channel's signed motor-power word on the rising edge of the core's `ce` strobe and converts it to sign/magnitude. It drives one PWM line plus one direction line per channel into the H-bridge pins. Duty and direction change only at PWM period boundaries, so no pulse is ever truncated. Optional dead-time suppresses drive for one full period on every direction reversal.

## Interface
Parameters:
- `aw`, 1: width of the channel address; channel count `an = 2^aw`.
- `ow`, 12: width of the signed input word; magnitude width is `mw = ow-1`.

Ports:
- `clk_pid`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `ce`, in, 1: data-valid level from the PID core, high for several cycles per channel slot.
- `a`, in, `aw`: channel address accompanying `m_k`.
- `m_k`, in, `ow`: signed motor power, two's complement.
- `pwm_out`, out, `an`: PWM drive, one bit per channel.
- `dir_out`, out, `an`: direction per channel; 1 = negative `m_k`.
- `sync`, out, 1: one-cycle pulse on the last cycle of each PWM period.

## Operation
- Edge capture:
  - `ce_d` registers `ce`.
  - When `ce & ~ce_d`, `pend_sign[a] <= m_k[ow-1]` and `pend_mag[a] <= |m_k|`.
  - `|m_k|` for `m_k = -2^(ow-1)` saturates to `2^mw - 1`.
  - Further cycles with `ce` still high are ignored, whatever `m_k` does.
- Period counter:
  - `cnt`, `mw` bits, is shared by all channels.
  - Counts 0 .. `PMAX = 2^mw - 2`, then wraps to 0.
  - Period is `2^mw - 1` cycles (2047 cycles at `ow=12`).
  - `sync = (cnt == PMAX)`.
- Boundary load: on every cycle with `cnt == PMAX`, each channel loads `act_mag`/`act_dir` from its pending registers. Dead-time rules are in Configuration.
- PWM output:
  - `pwm_out[i] = (cnt < act_mag[i])`, registered.
  - `act_mag = 0` gives constant low.
  - `act_mag = 2^mw - 1` gives constant high (100 %).
  - `dir_out[i] = act_dir[i]`, registered.
- Same-edge collision: a capture and a boundary load on the same channel in the same cycle → the load takes the pre-capture pending value. The new value applies one period later.
- `a` values are used only while a capture edge occurs; `a` is don't-care otherwise.

## Timing
- Reset values:
  - `cnt`, `ce_d`, all pending/active registers and the dead flags = 0.
  - `pwm_out = 0`, `dir_out = 0`, `sync = 0`.
  - Reset asserted mid-period clears all of the above on the next edge.
  - First period after release starts at `cnt = 0`.
- Capture latency: the edge where `ce` is first seen high (with `ce_d` low) writes the pending registers.
- Output latency:
  - Registered outputs reflect `cnt` and the active registers with one cycle latency.
  - The first `pwm_out` cycle using a newly loaded duty is the cycle after `cnt` returns to 0.
- Worst-case command-to-output delay: one full period + 2 cycles (+ one extra period with dead-time).
- Arithmetic: magnitude is computed in `ow` bits and truncated to `mw` after saturation. No other scaling is applied.

## Configuration
- `PID_PWM_DEADTIME_EN` defined:
  - At a boundary where pending sign ≠ `act_dir` and `act_mag ≠ 0`: load `act_mag = 0`, keep `act_dir`, set `dead[i]`.
  - At the next boundary: clear `dead[i]` and load both pending sign and magnitude.
  - A reversal from `act_mag = 0` is applied immediately.
- Undefined: direction and magnitude always load together at the boundary. No `dead` registers are synthesized.

## Test plan
- Reset → `pwm_out`, `dir_out`, `sync` all 0 for the whole first period; `sync` first pulses 2047 cycles after reset release.
- `ce` rise with `a=0`, `m_k=+512` → from the first period after the next boundary, `pwm_out[0]` is high for exactly 512 of 2047 cycles; `dir_out[0]=0`; channel 1 is unchanged.
- `m_k=-2048` on `a=1` → `dir_out[1]=1`, `pwm_out[1]` constantly high. `m_k=0` → constantly low.
- `ce` held high 6 cycles while `m_k` steps 100→200→300 → only 100 is captured.
- With `act` = +100, command -100:
  - Macro on: one period with `pwm_out` low and `dir_out` still 0, then `dir_out=1` with duty 100.
  - Macro off: `dir_out=1`, duty 100 at the first boundary.
- Capture on the `cnt==PMAX` cycle → the old duty runs one more period; the new duty appears in the period after that. `reset` pulse mid-period → all outputs 0 next cycle.
